// File: rtl/fifo_mst_arb_rr_pkg.sv
// Shared definitions for the FT60x FIFO master path: arbiter state encoding and sizing limits.
package pkg_ft601_ctrl_defines;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ARB,
    ARB_BUSY
  } arb_st_t;

  localparam int MAX_NUM_CHNLS   = 8;
  localparam int DEF_TIMEOUT_CYC = 4096;

endpackage

// File: rtl/fifo_arb_rr_pick.sv
// Rotating priority encoder: finds the first set req bit searching upward from last+1, wrapping at W.
module fifo_arb_rr_pick #(
  parameter int W  = 8,
  parameter int IW = (W > 1) ? $clog2(W) : 1
) (
  input  logic [W-1:0]  req,
  input  logic [IW-1:0] last,
  output logic          hit,
  output logic [IW-1:0] idx
);

  int cand;

  // NOTE: every output of a combinational block gets a default before any branch, otherwise a latch is inferred.
  always_comb begin
    hit  = 1'b0;
    idx  = '0;
    cand = 0;
    for (int off = 1; off <= W; off++) begin
      cand = int'(last) + off;
      if (cand >= W) cand = cand - W;
      if (!hit && req[cand[IW-1:0]]) begin
        hit = 1'b1;
        idx = cand[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/fifo_mst_arb_rr.sv
// Round-robin endpoint arbiter for the FT60x FIFO master path.
// Optional BUSY watchdog enabled by defining FIFO_MST_ARB_TIMEOUT_EN.
module fifo_mst_arb_rr
  import pkg_ft601_ctrl_defines::*;
#(
  parameter int NUM_CHNLS   = 4,
  parameter int EPW         = $clog2(NUM_CHNLS + 1),
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                   fifoClk,
  input  logic                   fifoRstn,
  input  logic                   idle_st,
  input  logic                   mem_rdy,
  input  logic [2*NUM_CHNLS-1:0] slv_f_st_n,
  input  logic [2*NUM_CHNLS-1:0] mst_f_st_n,
  input  logic                   xfer_done,
  output logic                   grant,
  output logic [EPW-1:0]         t_ep_num,
  output logic                   m_rd_wr,
  output logic                   busy,
  output logic                   timeout
);

  localparam int NREQ = 2 * NUM_CHNLS;
  localparam int IW   = $clog2(NREQ);

  arb_st_t         st, st_nxt;
  logic [NREQ-1:0] req, req_r;
  logic [IW-1:0]   last, win_idx, pick_idx;
  logic            pick_hit, win_vld;
  logic            load_req, clr_req, win_set, done, expire, tmo_hit;

  // Port layout groups OUT bits high and IN bits low; interleave into OUT1, IN1, OUT2, IN2, ...
  always_comb begin
    req = '0;
    for (int ch = 0; ch < NUM_CHNLS; ch++) begin
      req[2*ch]   = idle_st & ~slv_f_st_n[NUM_CHNLS+ch] & ~mst_f_st_n[NUM_CHNLS+ch];
      req[2*ch+1] = idle_st & ~slv_f_st_n[ch] & ~mst_f_st_n[ch];
    end
  end

  fifo_arb_rr_pick #(
    .W  (NREQ),
    .IW (IW)
  ) u_pick (
    .req  (req_r),
    .last (last),
    .hit  (pick_hit),
    .idx  (pick_idx)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge fifoClk or negedge fifoRstn) begin
    if (!fifoRstn) st <= ARB_IDLE;
    else           st <= st_nxt;
  end

  always_comb begin
    st_nxt   = st;
    load_req = 1'b0;
    clr_req  = 1'b0;
    win_set  = 1'b0;
    done     = 1'b0;
    expire   = 1'b0;
    case (st)
      ARB_IDLE: begin
        if (idle_st && mem_rdy) begin
          load_req = 1'b1;
          st_nxt   = ARB_ARB;
        end
      end
      ARB_ARB: begin
        clr_req = 1'b1;
        if (idle_st && pick_hit) begin
          win_set = 1'b1;
          st_nxt  = ARB_BUSY;
        end else begin
          st_nxt = ARB_IDLE;
        end
      end
      ARB_BUSY: begin
        // The first BUSY cycle only launches the grant; completion is accepted once busy is up.
        if (busy && xfer_done) begin
          done   = 1'b1;
          st_nxt = ARB_IDLE;
        end else if (busy && tmo_hit) begin
          expire = 1'b1;
          st_nxt = ARB_IDLE;
        end
      end
      default: st_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge fifoClk or negedge fifoRstn) begin
    if (!fifoRstn) begin
      req_r    <= '0;
      last     <= IW'(NREQ - 1);
      win_vld  <= 1'b0;
      win_idx  <= '0;
      grant    <= 1'b0;
      t_ep_num <= '0;
      m_rd_wr  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      if (load_req)     req_r <= req;
      else if (clr_req) req_r <= '0;
      win_vld <= win_set;
      if (win_set) win_idx <= pick_idx;
      grant <= win_vld;
      if (win_vld) begin
        t_ep_num <= EPW'(int'(win_idx) / 2 + 1);
        m_rd_wr  <= ~win_idx[0];
        last     <= win_idx;
        busy     <= 1'b1;
      end else if (done || expire) begin
        busy <= 1'b0;
      end
    end
  end

`ifdef FIFO_MST_ARB_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic [CW-1:0] tmo_cnt;

  always_ff @(posedge fifoClk or negedge fifoRstn) begin
    if (!fifoRstn) begin
      tmo_cnt <= '0;
      timeout <= 1'b0;
    end else begin
      if (win_vld)   tmo_cnt <= '0;
      else if (busy) tmo_cnt <= tmo_cnt + 1'b1;
      timeout <= expire;
    end
  end

  assign tmo_hit = (tmo_cnt == CW'(TIMEOUT_CYC - 1));
`else
  logic unused_tmo;

  assign unused_tmo = TIMEOUT_CYC[0];
  assign tmo_hit    = 1'b0;
  assign timeout    = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_mst_arb_rr.sv
// Randomised bench for fifo_mst_arb_rr against a queue-free round-robin reference model.
module tb_fifo_mst_arb_rr;

  localparam int N    = 4;
  localparam int NREQ = 2 * N;
  localparam int EPW  = $clog2(N + 1);
`ifdef FIFO_MST_ARB_TIMEOUT_EN
  localparam int TMO = 16;
`else
  localparam int TMO = 4096;
`endif

  logic            fifoClk, fifoRstn, idle_st, mem_rdy, xfer_done;
  logic [NREQ-1:0] slv_f_st_n, mst_f_st_n;
  logic            grant, m_rd_wr, busy, timeout;
  logic [EPW-1:0]  t_ep_num;

  fifo_mst_arb_rr #(
    .NUM_CHNLS   (N),
    .EPW         (EPW),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .fifoClk    (fifoClk),
    .fifoRstn   (fifoRstn),
    .idle_st    (idle_st),
    .mem_rdy    (mem_rdy),
    .slv_f_st_n (slv_f_st_n),
    .mst_f_st_n (mst_f_st_n),
    .xfer_done  (xfer_done),
    .grant      (grant),
    .t_ep_num   (t_ep_num),
    .m_rd_wr    (m_rd_wr),
    .busy       (busy),
    .timeout    (timeout)
  );

  initial fifoClk = 1'b0;
  always #5 fifoClk = ~fifoClk;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  int m_last = NREQ - 1;
  int m_ep   = 0;
  int m_rw   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge fifoClk);
    #1;
  endtask

  // Requestor k is channel k/2+1, OUT when k even; OUT status sits at bit N+ch-1, IN at bit ch-1.
  function automatic int model_pick(input logic [NREQ-1:0] slv, input logic [NREQ-1:0] mst,
                                    input int last);
    for (int off = 1; off <= NREQ; off++) begin
      int k    = (last + off) % NREQ;
      int ch   = k / 2 + 1;
      int bitn = (k % 2 == 0) ? N + ch - 1 : ch - 1;
      if (!slv[bitn] && !mst[bitn]) return k;
    end
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] rnd_vec();
    return NREQ'($urandom);
  endfunction

  // Starts at #1 after an edge with the DUT idle; ends at #1 after an edge.
  // With release_busy=0 a granted transfer is left in BUSY, one cycle after the grant edge.
  task automatic txn(input logic [NREQ-1:0] slv, input logic [NREQ-1:0] mst,
                     input bit drop_idle, input bit release_busy);
    int k, lat;
    bit seen;
    k = drop_idle ? -1 : model_pick(slv, mst, m_last);
    slv_f_st_n = slv;
    mst_f_st_n = mst;
    idle_st    = 1'b1;
    mem_rdy    = 1'b1;
    tick();
    mem_rdy    = 1'b0;
    slv_f_st_n = rnd_vec();
    mst_f_st_n = rnd_vec();
    if (drop_idle) idle_st = 1'b0;
    seen = 1'b0;
    lat  = -1;
    for (int i = 0; i < 6 && !seen; i++) begin
      @(negedge fifoClk);
      if (grant) begin
        seen = 1'b1;
        lat  = i;
      end
    end
    if (k < 0) begin
      check("no_grant", 32'(seen), 0);
      check("ep_hold", 32'(t_ep_num), m_ep);
      check("idle_busy", 32'(busy), 0);
      tick();
      idle_st = 1'b1;
      return;
    end
    check("grant_seen", 32'(seen), 1);
    check("latency", lat, 2);
    check("ep", 32'(t_ep_num), (k / 2) + 1);
    check("rd_wr", 32'(m_rd_wr), (k % 2 == 0) ? 1 : 0);
    check("busy_rise", 32'(busy), 1);
    m_last = k;
    m_ep   = k / 2 + 1;
    m_rw   = (k % 2 == 0) ? 1 : 0;
    tick();
    check("grant_pulse", 32'(grant), 0);
    if (!release_busy) return;
    repeat ($urandom_range(0, 3)) tick();
    check("busy_hold", 32'(busy), 1);
    xfer_done = 1'b1;
    tick();
    xfer_done = 1'b0;
    check("busy_fall", 32'(busy), 0);
    check("tmo_quiet", 32'(timeout), 0);
  endtask

  // Expects the DUT one cycle after a grant edge, still BUSY.
  task automatic watchdog_expire();
    int at;
    at = -1;
    for (int c = 1; c <= 40; c++) begin
      if (timeout && at < 0) begin
        at = c;
        check("tmo_busy", 32'(busy), 0);
      end
      tick();
    end
`ifdef FIFO_MST_ARB_TIMEOUT_EN
    check("tmo_at", at, TMO);
`else
    check("tmo_never", at, -1);
    check("busy_wait", 32'(busy), 1);
    xfer_done = 1'b1;
    tick();
    xfer_done = 1'b0;
    check("busy_fall", 32'(busy), 0);
`endif
  endtask

  initial begin
    logic [NREQ-1:0] all1;
    all1       = '1;
    fifoRstn   = 1'b0;
    idle_st    = 1'b0;
    mem_rdy    = 1'b0;
    xfer_done  = 1'b0;
    slv_f_st_n = all1;
    mst_f_st_n = all1;
    repeat (3) @(posedge fifoClk);
    @(negedge fifoClk);
    fifoRstn = 1'b1;
    tick();

    check("rst_grant", 32'(grant), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_ep", 32'(t_ep_num), 0);
    check("rst_rw", 32'(m_rd_wr), 0);
    check("rst_tmo", 32'(timeout), 0);

    // OUT1 (bit 4) and IN3 (bit 2) ready
    txn(~NREQ'(8'h14), ~NREQ'(8'h14), 1'b0, 1'b1);
    txn(~NREQ'(8'h14), ~NREQ'(8'h14), 1'b0, 1'b1);

    // all requestors ready: two full rotations
    for (int g = 0; g < 2 * NREQ; g++) txn('0, '0, 1'b0, 1'b1);

    // IN2 slave ready, master not ready
    txn(~NREQ'(8'h02), all1, 1'b0, 1'b1);

    // idle_st withdrawn during the ARB cycle
    txn('0, '0, 1'b1, 1'b1);

    // stray completion while idle
    xfer_done = 1'b1;
    tick();
    xfer_done = 1'b0;
    check("stray_done_busy", 32'(busy), 0);
    check("stray_done_grant", 32'(grant), 0);

    for (int t = 0; t < 40; t++)
      txn(rnd_vec(), rnd_vec(), ($urandom_range(0, 7) == 0), 1'b1);

    // watchdog: no completion
    txn('0, '0, 1'b0, 1'b0);
    watchdog_expire();
`ifdef FIFO_MST_ARB_TIMEOUT_EN
    // completion in the same cycle as expiry wins
    txn('0, '0, 1'b0, 1'b0);
    repeat (TMO - 2) tick();
    xfer_done = 1'b1;
    tick();
    xfer_done = 1'b0;
    check("tie_busy", 32'(busy), 0);
    check("tie_tmo", 32'(timeout), 0);
    tick();
    check("tie_tmo_late", 32'(timeout), 0);
`endif
    txn('0, '0, 1'b0, 1'b1);

    // reset during BUSY
    txn('0, '0, 1'b0, 1'b0);
    tick();
    fifoRstn = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_grant", 32'(grant), 0);
    check("mid_rst_ep", 32'(t_ep_num), 0);
    @(negedge fifoClk);
    fifoRstn = 1'b1;
    m_last   = NREQ - 1;
    m_ep     = 0;
    m_rw     = 0;
    tick();
    check("post_rst_tmo", 32'(timeout), 0);
    txn('0, '0, 1'b0, 1'b1);
    check("post_rst_ep", 32'(t_ep_num), 1);
    check("post_rst_rw", 32'(m_rd_wr), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
